// File: rtl/mac_tile_pkg.sv
// Shared constants for the dual-mode systolic MAC tile.
// Instruction bit positions and mode encodings.
package mac_tile_pkg;

  localparam int INST_LOAD  = 0;
  localparam int INST_EXEC  = 1;
  localparam int INST_DRAIN = 2;
  localparam int INST_W     = 3;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

endpackage

// File: rtl/mac_tile_dual_mac.sv
// Combinational multiply-add: unsigned a times signed b, plus c.
// Product is sign-extended to the psum width; the add wraps.
module mac_tile_dual_mac #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic [bw-1:0]      a,
  input  logic [bw-1:0]      b,
  input  logic [psum_bw-1:0] c,
  output logic [psum_bw-1:0] out
);

  logic signed [2*bw:0] a_ext;
  logic signed [2*bw:0] b_ext;
  logic signed [2*bw:0] prod;
  logic [psum_bw-1:0]   prod_ext;

  assign a_ext = $signed({{(bw+1){1'b0}}, a});
  assign b_ext = $signed({{(bw+1){b[bw-1]}}, b});
  assign prod  = a_ext * b_ext;

  assign prod_ext = {{(psum_bw-2*bw-1){prod[2*bw]}}, prod};
  assign out      = prod_ext + c;

endmodule

// File: rtl/mac_tile_dual.sv
// Dual-mode systolic PE: weight-stationary or output-stationary.
// Activations/instructions flow east, weights/psums flow south.
module mac_tile_dual
  import mac_tile_pkg::*;
#(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  input  logic [INST_W-1:0]  inst_w,
  input  logic [psum_bw-1:0] in_n,
  output logic [bw-1:0]      out_e,
  output logic [INST_W-1:0]  inst_e,
  output logic [psum_bw-1:0] out_s,
  output logic               loaded
);

  logic [bw-1:0]      a_q;
  logic [bw-1:0]      b_q;
  logic [psum_bw-1:0] c_q;
  logic [psum_bw-1:0] acc_q;
  logic               mode_q;
  logic               load_ready_q;
  logic               exec_q;
  logic [INST_W-1:0]  inst_q;

  logic [psum_bw-1:0] mac_c;
  logic [psum_bw-1:0] mac_out;

  assign mac_c = (mode_q == MODE_OS) ? acc_q : c_q;

  mac_tile_dual_mac #(
    .bw      (bw),
    .psum_bw (psum_bw)
  ) u_mac (
    .a   (a_q),
    .b   (b_q),
    .c   (mac_c),
    .out (mac_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      acc_q        <= '0;
      mode_q       <= MODE_WS;
      load_ready_q <= 1'b1;
      exec_q       <= 1'b0;
      inst_q       <= '0;
    end else if (mode != mode_q) begin
      mode_q       <= mode;
      acc_q        <= '0;
      exec_q       <= 1'b0;
      load_ready_q <= 1'b1;
      inst_q       <= '0;
    end else if (mode_q == MODE_WS) begin
      // The first load after reset/switch is consumed by this tile.
      if (inst_w[INST_LOAD] && load_ready_q) begin
        b_q               <= in_w;
        load_ready_q      <= 1'b0;
        inst_q[INST_LOAD] <= 1'b0;
      end else begin
        inst_q[INST_LOAD] <= inst_w[INST_LOAD];
      end
      inst_q[INST_EXEC]  <= inst_w[INST_EXEC];
      inst_q[INST_DRAIN] <= inst_w[INST_DRAIN];
      if (inst_w[INST_LOAD] || inst_w[INST_EXEC])
        a_q <= in_w;
      if (inst_w[INST_EXEC])
        c_q <= in_n;
    end else begin
      exec_q <= inst_w[INST_EXEC];
      if (inst_w[INST_EXEC]) begin
        a_q <= in_w;
        b_q <= in_n[bw-1:0];
      end
      // Drain wins over a pending accumulate.
      if (inst_w[INST_DRAIN])
        acc_q <= in_n;
      else if (exec_q)
        acc_q <= mac_out;
      inst_q <= inst_w;
    end
  end

  always_comb begin
    out_s = mac_out;
    if (mode_q == MODE_OS) begin
      if (inst_w[INST_DRAIN])
        out_s = acc_q;
      else
        out_s = {{(psum_bw-bw){b_q[bw-1]}}, b_q};
    end
  end

  assign out_e  = a_q;
  assign inst_e = inst_q;
  assign loaded = ~load_ready_q;

endmodule

// File: tb/tb_mac_tile_dual.sv
// Randomized and directed bench for mac_tile_dual.
// A cycle-level arithmetic model predicts every output.
module tb_mac_tile_dual;

  logic        clk;
  logic        reset;
  logic        mode;
  logic [3:0]  in_w;
  logic [2:0]  inst_w;
  logic [15:0] in_n;
  logic [3:0]  out_e;
  logic [2:0]  inst_e;
  logic [15:0] out_s;
  logic        loaded;

  int n_pass = 0;
  int n_total = 0;

  // model state
  bit       m_mode;
  int       m_a;
  int       m_w;
  int       m_c;
  int       m_acc;
  bit       m_ready;
  bit       m_pend;
  int       m_pval;
  bit [2:0] m_inst;

  mac_tile_dual #(.bw(4), .psum_bw(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .mode   (mode),
    .in_w   (in_w),
    .inst_w (inst_w),
    .in_n   (in_n),
    .out_e  (out_e),
    .inst_e (inst_e),
    .out_s  (out_s),
    .loaded (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sx4(logic [3:0] x);
    return x[3] ? int'(x) - 16 : int'(x);
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 1'b0; m_a = 0; m_w = 0; m_c = 0; m_acc = 0;
    m_ready = 1'b1; m_pend = 1'b0; m_pval = 0; m_inst = 3'b000;
  endtask

  task automatic model_step();
    bit [2:0] ni;
    if (!reset) begin
      model_reset();
    end else if (mode != m_mode) begin
      m_mode = mode; m_acc = 0; m_pend = 1'b0;
      m_ready = 1'b1; m_inst = 3'b000;
    end else if (!m_mode) begin
      ni = inst_w;
      if (inst_w[0] && m_ready) begin
        m_w = sx4(in_w); m_ready = 1'b0; ni[0] = 1'b0;
      end
      if (inst_w[0] || inst_w[1]) m_a = int'(in_w);
      if (inst_w[1]) m_c = int'(in_n);
      m_inst = ni;
    end else begin
      if (inst_w[2]) m_acc = int'(in_n);
      else if (m_pend) m_acc = (m_acc + m_pval) & 'hFFFF;
      m_pend = inst_w[1];
      if (inst_w[1]) begin
        m_a = int'(in_w);
        m_w = sx4(in_n[3:0]);
        m_pval = m_a * m_w;
      end
      m_inst = inst_w;
    end
  endtask

  task automatic cmp_model();
    logic [15:0] es;
    if (!m_mode) es = 16'(m_a * m_w + m_c);
    else if (inst_w[2]) es = 16'(m_acc);
    else es = 16'(m_w);
    check("model_out_s", out_s, es);
    check("model_out_e", {12'h0, out_e}, {12'h0, 4'(m_a)});
    check("model_inst_e", {13'h0, inst_e}, {13'h0, m_inst});
    check("model_loaded", {15'h0, loaded}, {15'h0, ~m_ready});
  endtask

  task automatic apply(bit r, bit m, logic [2:0] i, logic [3:0] w,
                       logic [15:0] n);
    reset = r; mode = m; inst_w = i; in_w = w; in_n = n;
    if (!r) model_reset();
    @(negedge clk);
    cmp_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    bit cm;
    reset = 1'b0; mode = 1'b0; inst_w = 3'b000; in_w = 4'h0; in_n = 16'h0;
    model_reset();
    #1;
    apply(1'b0, 1'b0, 3'b000, 4'h0, 16'h0);
    check("rst_out_s", out_s, 16'h0);
    check("rst_loaded", {15'h0, loaded}, 16'h0);
    tick();

    // WS load, second load, exec
    apply(1'b1, 1'b0, 3'b001, 4'hD, 16'h0);
    tick();
    apply(1'b1, 1'b0, 3'b001, 4'h1, 16'h0);
    check("ws_loaded", {15'h0, loaded}, 16'h1);
    check("ws_first_inst_e", {13'h0, inst_e}, 16'h0);
    check("ws_out_e", {12'h0, out_e}, 16'hD);
    tick();
    apply(1'b1, 1'b0, 3'b010, 4'h5, 16'd100);
    check("ws_second_inst_e", {13'h0, inst_e}, 16'h1);
    tick();
    apply(1'b1, 1'b0, 3'b000, 4'h0, 16'h0);
    check("ws_psum", out_s, 16'd85);
    tick();

    // switch to OS
    apply(1'b1, 1'b1, 3'b000, 4'h0, 16'h0);
    tick();
    apply(1'b1, 1'b1, 3'b000, 4'h0, 16'h0);
    check("sw_loaded", {15'h0, loaded}, 16'h0);
    tick();
    apply(1'b1, 1'b1, 3'b100, 4'h0, 16'h0);
    check("sw_acc_clear", out_s, 16'h0);
    tick();

    // OS accumulate 6 - 4 + 14
    apply(1'b1, 1'b1, 3'b010, 4'd2, 16'd3);
    tick();
    apply(1'b1, 1'b1, 3'b010, 4'd4, 16'hFFFF);
    check("os_weight_pos", out_s, 16'd3);
    tick();
    apply(1'b1, 1'b1, 3'b010, 4'd7, 16'd2);
    check("os_weight_neg", out_s, 16'hFFFF);
    tick();
    apply(1'b1, 1'b1, 3'b000, 4'h0, 16'h0);
    tick();
    apply(1'b1, 1'b1, 3'b100, 4'h0, 16'h0042);
    check("os_drain_acc", out_s, 16'd16);
    tick();
    apply(1'b1, 1'b1, 3'b000, 4'h0, 16'h0);
    check("os_drain_inst_e", {13'h0, inst_e}, 16'h4);
    tick();
    apply(1'b1, 1'b1, 3'b100, 4'h0, 16'h0);
    check("os_shift_in", out_s, 16'h0042);
    tick();

    // collision: drain right after exec drops the product
    apply(1'b1, 1'b1, 3'b010, 4'd2, 16'd5);
    tick();
    apply(1'b1, 1'b1, 3'b000, 4'h0, 16'h0);
    tick();
    apply(1'b1, 1'b1, 3'b010, 4'd3, 16'd3);
    tick();
    apply(1'b1, 1'b1, 3'b100, 4'h0, 16'h0055);
    check("col_drain", out_s, 16'd10);
    tick();
    apply(1'b1, 1'b1, 3'b100, 4'h0, 16'h0);
    check("col_discard", out_s, 16'h0055);
    tick();

    // wrap
    apply(1'b1, 1'b1, 3'b100, 4'h0, 16'hFFFF);
    tick();
    apply(1'b1, 1'b1, 3'b010, 4'd1, 16'd1);
    tick();
    apply(1'b1, 1'b1, 3'b000, 4'h0, 16'h0);
    tick();
    apply(1'b1, 1'b1, 3'b100, 4'h0, 16'h0);
    check("wrap", out_s, 16'h0);
    tick();

    // reset mid-accumulation
    apply(1'b1, 1'b1, 3'b100, 4'h0, 16'd37);
    tick();
    apply(1'b1, 1'b1, 3'b010, 4'd1, 16'd1);
    tick();
    apply(1'b0, 1'b1, 3'b000, 4'h0, 16'h0);
    check("mid_rst_out_s", out_s, 16'h0);
    check("mid_rst_out_e", {12'h0, out_e}, 16'h0);
    check("mid_rst_inst_e", {13'h0, inst_e}, 16'h0);
    check("mid_rst_loaded", {15'h0, loaded}, 16'h0);
    tick();
    apply(1'b1, 1'b0, 3'b001, 4'd6, 16'h0);
    tick();
    apply(1'b1, 1'b0, 3'b000, 4'h0, 16'h0);
    check("post_rst_loaded", {15'h0, loaded}, 16'h1);
    check("post_rst_inst_e", {13'h0, inst_e}, 16'h0);
    tick();

    // random traffic with occasional mode switches
    cm = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        apply(1'b1, cm, 3'b000, 4'($urandom), 16'($urandom));
        tick();
        cm = ~cm;
        apply(1'b1, cm, 3'b000, 4'($urandom), 16'($urandom));
        tick();
        apply(1'b1, cm, 3'b000, 4'($urandom), 16'($urandom));
        tick();
      end else if ($urandom_range(0, 199) == 0) begin
        apply(1'b0, cm, 3'($urandom), 4'($urandom), 16'($urandom));
        tick();
        cm = 1'b0;
      end else begin
        apply(1'b1, cm, 3'($urandom), 4'($urandom), 16'($urandom));
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
